// File: rtl/bit_counter_ctrl.sv
// Control FSM for the bit-counter datapath: operand handshake, load/shift/done
// sequencing and a held result handshake. Optional early exit: BC_EARLY_EXIT_EN.
module bit_counter_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       z,
  input  logic [3:0] result_in,
  output logic       load_b,
  output logic       result_shift,
  output logic       done,
  output logic       out_valid,
  output logic [3:0] out_result,
  input  logic       out_ready
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > 15) begin : g_width_check
    $error("bit_counter_ctrl: WIDTH must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE,
    S_HOLD
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_shift_cnt;
  logic             w_early_exit;

`ifdef BC_EARLY_EXIT_EN
  // Remaining operand already zero: further shifts cannot add to the count.
  assign w_early_exit = z;
`else
  logic w_unused_z;
  assign w_unused_z   = z;
  assign w_early_exit = 1'b0;
`endif

  assign in_ready = (r_state == S_IDLE);

  // NOTE: every strobe gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    load_b       = 1'b0;
    result_shift = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE:  load_b       = in_valid;
      S_SHIFT: result_shift = ~w_early_exit;
      S_DONE:  done         = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_shift_cnt <= '0;
      out_valid   <= 1'b0;
      out_result  <= 4'h0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shift_cnt <= '0;
            r_state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_early_exit) begin
            r_state <= S_DONE;
          end else begin
            r_shift_cnt <= r_shift_cnt + CNT_W'(1);
            if (r_shift_cnt == LAST_CNT) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          out_result <= result_in;
          out_valid  <= 1'b1;
          r_state    <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0({load_b, result_shift, done}))
        else $error("bit_counter_ctrl: more than one datapath strobe high");
    end
  end
`endif

endmodule

// File: tb/tb_bit_counter_ctrl.sv
// Self-checking bench for bit_counter_ctrl: a behavioural datapath drives z and
// result_in; expected counts and latencies come from popcount / MSB arithmetic.
module tb_bit_counter_ctrl;

  localparam int W = 8;
`ifdef BC_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         z;
  logic [3:0]   result_in;
  logic         load_b;
  logic         result_shift;
  logic         done;
  logic         out_valid;
  logic [3:0]   out_result;
  logic         out_ready;
  logic [W-1:0] a_bus;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bit_counter_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .z           (z),
    .result_in   (result_in),
    .load_b      (load_b),
    .result_shift(result_shift),
    .done        (done),
    .out_valid   (out_valid),
    .out_result  (out_result),
    .out_ready   (out_ready)
  );

  // Behavioural datapath: load operand, shift right accumulating LSBs.
  logic [W-1:0] dp_a;
  logic [3:0]   dp_cnt;
  always @(posedge clk) begin
    if (reset) begin
      dp_a   <= '0;
      dp_cnt <= 4'h0;
    end else if (load_b) begin
      dp_a   <= a_bus;
      dp_cnt <= 4'h0;
    end else if (result_shift) begin
      dp_cnt <= dp_cnt + {3'b000, dp_a[0]};
      dp_a   <= dp_a >> 1;
    end
  end
  assign z         = (dp_a == '0);
  assign result_in = done ? dp_cnt : 4'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int popcount(input logic [W-1:0] a);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(a[i]);
    return n;
  endfunction

  function automatic int msb_k(input logic [W-1:0] a);
    int k = 0;
    for (int i = 0; i < W; i++) if (a[i]) k = i + 1;
    return k;
  endfunction

  // One full transaction from accept to output handshake.
  task automatic run_op(input logic [W-1:0] a, input int stall, input bit hold_valid);
    int k, lat, exp_shifts, budget;
    int n_shift, n_done, done_cyc, n_load, n_ov, n_ir;
    logic [3:0] held;
    budget = 0;
    while (!in_ready && budget < 50) begin
      tick();
      budget++;
    end
    check("in_ready_before_accept", in_ready, 1);
    a_bus    = a;
    in_valid = 1'b1;
    #1;
    check("load_b_on_accept", load_b, 1);
    tick();  // E0

    k          = msb_k(a);
    exp_shifts = EARLY ? ((k < W) ? k : W) : W;
    lat        = EARLY ? (((k + 1 < W) ? k + 1 : W) + 1) : W + 1;

    n_shift = 0; n_done = 0; done_cyc = -1; n_load = 0; n_ov = 0; n_ir = 0;
    for (int cyc = 1; cyc <= lat; cyc++) begin
      in_valid  = hold_valid ? 1'b1 : 1'($urandom_range(1, 0));
      a_bus     = W'($urandom);
      out_ready = 1'($urandom_range(1, 0));
      #1;
      n_shift += int'(result_shift);
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      n_load += int'(load_b);
      n_ov   += int'(out_valid);
      n_ir   += int'(in_ready);
      tick();
    end
    check("shift_cycles", n_shift, exp_shifts);
    check("done_count", n_done, 1);
    check("done_cycle", done_cyc, lat);
    check("load_b_while_busy", n_load, 0);
    check("out_valid_early", n_ov, 0);
    check("in_ready_while_busy", n_ir, 0);
    check("out_valid_rise", out_valid, 1);
    check("out_result", out_result, popcount(a));

    held      = out_result;
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      in_valid = hold_valid ? 1'b1 : 1'($urandom_range(1, 0));
      tick();
      check("stall_out_valid", out_valid, 1);
      check("stall_out_result", out_result, held);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid  = hold_valid;
    tick();
    check("handshake_out_valid", out_valid, 0);
    check("handshake_in_ready", in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_bus     = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_load_b", load_b, 0);
    check("rst_result_shift", result_shift, 0);
    check("rst_done", done, 0);

    run_op(8'h67, 0, 1'b0);
    run_op(8'hC3, 0, 1'b1);
    run_op(8'hFF, 0, 1'b0);
    run_op(8'h0F, 5, 1'b0);
    run_op(8'h00, 1, 1'b0);
    run_op(8'h01, 2, 1'b0);

    // Reset in the fourth SHIFT cycle of 0xAA.
    a_bus    = 8'hAA;
    in_valid = 1'b1;
    #1;
    tick();  // E0
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("mid_in_shift", result_shift, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mid_load_b", load_b, 0);
    check("mid_result_shift", result_shift, 0);
    check("mid_done", done, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_out_result", out_result, 0);
    check("mid_idle", in_ready, 1);
    run_op(8'h81, 0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      run_op(W'($urandom), int'($urandom_range(3, 0)),
             (i == 24) ? 1'b0 : 1'($urandom_range(1, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
